anim_frame_sequencer: RTL

//  Sequences the 5-bit frame index that drives the LED animation pattern

---
 rtl/anim_frame_sequencer_if.sv | 36 +++
 rtl/anim_frame_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/anim_frame_sequencer_if.sv
// Control/status bundle between the board controls and anim_frame_sequencer.
// Build option: none here (ANIM_PINGPONG_EN is consumed by the sequencer).
//   start      1-cycle pulse: (re)start playback
//   stop       1-cycle pulse: abort to idle
//   hold       level: pause while high
//   dir        0 = forward, 1 = reverse (sampled on start)
//   mode       0 one-shot, 1 loop, 2 ping-pong, 3 loop (sampled on start)
//   speed      frame period = BASE_DIV << speed cycles
//   frame_idx  registered frame index to the decoders
//   frame_tick 1-cycle pulse on each frame advance
//   busy       high while running or paused
//   done       1-cycle pulse on one-shot completion
interface anim_frame_sequencer_if #(
    parameter int unsigned FRAME_W = 5
);
    logic               start;
    logic               stop;
    logic               hold;
    logic               dir;
    logic [1:0]         mode;
    logic [2:0]         speed;
    logic [FRAME_W-1:0] frame_idx;
    logic               frame_tick;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, hold, dir, mode, speed,
        input  frame_idx, frame_tick, busy, done
    );

    modport slave (
        input  start, stop, hold, dir, mode, speed,
        output frame_idx, frame_tick, busy, done
    );
endinterface

// File: rtl/anim_frame_sequencer.sv
// Frame index sequencer for the LED animation decoder bank.
// Prescaled frame timing, one-shot / loop / ping-pong playback, forward or
// reverse, pause on hold.
// Build option: define ANIM_PINGPONG_EN to build ping-pong for mode 2;
// without it mode 2 plays exactly as loop.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    anim_frame_sequencer_if slave (controls in, frame/status out)
module anim_frame_sequencer #(
    parameter int unsigned FRAME_W     = 5,
    parameter int unsigned FIRST_FRAME = 0,
    parameter int unsigned LAST_FRAME  = 31,
    parameter int unsigned BASE_DIV    = 50000,
    parameter int unsigned DIV_W       = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    anim_frame_sequencer_if.slave bus
);
    localparam logic [FRAME_W-1:0] FirstIdx = FRAME_W'(FIRST_FRAME);
    localparam logic [FRAME_W-1:0] LastIdx  = FRAME_W'(LAST_FRAME);
    localparam logic [FRAME_W-1:0] IdxOne   = FRAME_W'(1);
    localparam logic [DIV_W-1:0]   CntOne   = DIV_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   period_q, period_d;
    logic               cur_dir_q, cur_dir_d;
    logic [1:0]         mode_q, mode_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic               busy;

    function automatic logic [DIV_W-1:0] period_of(input logic [2:0] spd);
        return DIV_W'(BASE_DIV) << spd;
    endfunction

    // Counting happens on any RUN/PAUSE edge where hold is low, so leaving
    // PAUSE resumes the count on the same edge that hold is seen low.
    logic running, frame_end, at_end, one_shot;
    assign running   = ((state_q == StRun) || (state_q == StPause)) && !bus.hold;
    assign frame_end = running && (cnt_q == period_q - CntOne);
    assign at_end    = cur_dir_q ? (idx_q == FirstIdx) : (idx_q == LastIdx);
    assign one_shot  = (mode_q == 2'd0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next state: stop > start > hold
    always_comb begin
        state_d = state_q;
        if (bus.stop) begin
            state_d = StIdle;
        end else if (bus.start) begin
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun, StPause: begin
                    if (bus.hold)                        state_d = StPause;
                    else if (frame_end && at_end && one_shot) state_d = StDone;
                    else                                 state_d = StRun;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q == StRun) || (state_q == StPause);
    end

    // Datapath next values
    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        cur_dir_d = cur_dir_q;
        mode_d    = mode_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        if (bus.stop) begin
            idx_d = FirstIdx;
            cnt_d = '0;
        end else if (bus.start) begin
            mode_d    = bus.mode;
            cur_dir_d = bus.dir;
            period_d  = period_of(bus.speed);
            idx_d     = bus.dir ? LastIdx : FirstIdx;
            cnt_d     = '0;
        end else if (running) begin
            if (frame_end) begin
                cnt_d = '0;
                if (at_end && one_shot) begin
                    done_d = 1'b1;
                end else begin
                    tick_d   = 1'b1;
                    // speed changes take effect from the next frame
                    period_d = period_of(bus.speed);
                    if (!at_end) begin
                        idx_d = cur_dir_q ? idx_q - IdxOne : idx_q + IdxOne;
                    end else begin
`ifdef ANIM_PINGPONG_EN
                        if (mode_q == 2'd2) begin
                            // bounce: end frame shown once, then step back
                            cur_dir_d = ~cur_dir_q;
                            idx_d     = cur_dir_q ? idx_q + IdxOne : idx_q - IdxOne;
                        end else begin
                            idx_d = cur_dir_q ? LastIdx : FirstIdx;
                        end
`else
                        idx_d = cur_dir_q ? LastIdx : FirstIdx;
`endif
                    end
                end
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= FirstIdx;
            cnt_q     <= '0;
            period_q  <= DIV_W'(BASE_DIV);
            cur_dir_q <= 1'b0;
            mode_q    <= 2'd0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            cur_dir_q <= cur_dir_d;
            mode_q    <= mode_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end

    assign bus.frame_idx  = idx_q;
    assign bus.frame_tick = tick_q;
    assign bus.busy       = busy;
    assign bus.done       = done_q;
endmodule
